// File: rtl/bee_game_ctrl.sv
// Per-frame sequencer for the bee sprite: frame tick, position with clamping, lives and game FSM.
// Optional WRAP_X_EN: horizontal motion wraps around the playfield instead of clamping.
module bee_game_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SPR_W       = 34,
  parameter int SPR_H       = 27,
  parameter int START_X     = 0,
  parameter int START_Y     = 300,
  parameter int SPEED       = 3,
  parameter int LIVES       = 3,
  parameter int HIT_FRAMES  = 60,
  parameter int OVER_FRAMES = 120
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       btn_start,
  input  logic       move_r,
  input  logic       move_l,
  input  logic       move_u,
  input  logic       move_d,
  input  logic       hit,
  output logic       frame_tick,
  output logic [9:0] bee_x,
  output logic [8:0] bee_y,
  output logic       bee_en,
  output logic [1:0] state,
  output logic [1:0] lives
);

  localparam int X_MAX = H_RES - SPR_W;
  localparam int Y_MAX = V_RES - SPR_H;
  localparam int T_MAX = (HIT_FRAMES > OVER_FRAMES) ? HIT_FRAMES : OVER_FRAMES;
  // At least 3 bits so the blink bit timer[2] always exists.
  localparam int TW    = ($clog2(T_MAX + 1) < 3) ? 3 : $clog2(T_MAX + 1);
  localparam logic [TW-1:0] HIT_T  = TW'(HIT_FRAMES);
  localparam logic [TW-1:0] OVER_T = TW'(OVER_FRAMES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_HIT = 2'd2, S_OVER = 2'd3} state_t;

  state_t          st, st_n;
  logic [9:0]      x_n, x_mv;
  logic [8:0]      y_n, y_mv;
  logic [1:0]      lives_n;
  logic            en_n;
  logic [TW-1:0]   tmr, tmr_n, tmr_dec;
  logic            hit_pend, hit_now, end_of_frame;
  logic [10:0]     x_inc, y_inc;

  assign end_of_frame = (sx == 10'(H_RES - 1)) && (sy == 10'(V_RES - 1));
  // A hit arriving on the tick cycle itself still counts for that tick.
  assign hit_now      = hit_pend || (hit && st == S_PLAY);
  assign tmr_dec      = tmr - TW'(1);
  assign state        = st;
  assign x_inc        = {1'b0, bee_x} + 11'(SPEED);
  assign y_inc        = {2'b00, bee_y} + 11'(SPEED);

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    x_mv = bee_x;
    if (move_r && !move_l) begin
`ifdef WRAP_X_EN
      x_mv = (x_inc > 11'(X_MAX)) ? 10'd0 : x_inc[9:0];
`else
      x_mv = (x_inc > 11'(X_MAX)) ? 10'(X_MAX) : x_inc[9:0];
`endif
    end else if (move_l && !move_r) begin
`ifdef WRAP_X_EN
      x_mv = (bee_x >= 10'(SPEED)) ? bee_x - 10'(SPEED) : 10'(X_MAX);
`else
      x_mv = (bee_x >= 10'(SPEED)) ? bee_x - 10'(SPEED) : 10'd0;
`endif
    end

    y_mv = bee_y;
    if (move_d && !move_u)
      y_mv = (y_inc > 11'(Y_MAX)) ? 9'(Y_MAX) : y_inc[8:0];
    else if (move_u && !move_d)
      y_mv = (bee_y >= 9'(SPEED)) ? bee_y - 9'(SPEED) : 9'd0;
  end

  always_comb begin
    st_n    = st;
    x_n     = bee_x;
    y_n     = bee_y;
    lives_n = lives;
    en_n    = bee_en;
    tmr_n   = tmr;
    if (frame_tick) begin
      unique case (st)
        S_IDLE: begin
          x_n     = 10'(START_X);
          y_n     = 9'(START_Y);
          lives_n = 2'(LIVES);
          en_n    = 1'b1;
          if (btn_start) st_n = S_PLAY;
        end
        S_PLAY: begin
          en_n = 1'b1;
          if (hit_now) begin
            lives_n = lives - 2'd1;
            if (lives == 2'd1) begin
              st_n  = S_OVER;
              tmr_n = OVER_T;
              en_n  = 1'b0;
            end else begin
              st_n  = S_HIT;
              tmr_n = HIT_T;
              en_n  = HIT_T[2];
            end
          end else begin
            x_n = x_mv;
            y_n = y_mv;
          end
        end
        S_HIT: begin
          if (tmr == TW'(1)) begin
            st_n  = S_PLAY;
            x_n   = 10'(START_X);
            y_n   = 9'(START_Y);
            en_n  = 1'b1;
            tmr_n = '0;
          end else begin
            tmr_n = tmr_dec;
            en_n  = tmr_dec[2];
          end
        end
        S_OVER: begin
          en_n = 1'b0;
          if (tmr == TW'(1)) begin
            st_n    = S_IDLE;
            lives_n = 2'(LIVES);
            x_n     = 10'(START_X);
            y_n     = 9'(START_Y);
            en_n    = 1'b1;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr_dec;
          end
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      bee_x      <= 10'(START_X);
      bee_y      <= 9'(START_Y);
      lives      <= 2'(LIVES);
      bee_en     <= 1'b1;
      frame_tick <= 1'b0;
      tmr        <= '0;
      hit_pend   <= 1'b0;
    end else begin
      frame_tick <= end_of_frame;
      st         <= st_n;
      bee_x      <= x_n;
      bee_y      <= y_n;
      lives      <= lives_n;
      bee_en     <= en_n;
      tmr        <= tmr_n;
      if (frame_tick || st != S_PLAY) hit_pend <= 1'b0;
      else if (hit)                   hit_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bee_game_ctrl.sv
// Directed self-checking bench for bee_game_ctrl using compressed frames (end-of-frame pulsed directly).
// Expected X values differ when WRAP_X_EN is defined.
module tb_bee_game_ctrl;

  logic       clk_pix = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sx = '0, sy = '0;
  logic       btn_start = 1'b0, move_r = 1'b0, move_l = 1'b0, move_u = 1'b0, move_d = 1'b0, hit = 1'b0;
  logic       frame_tick, bee_en;
  logic [9:0] bee_x;
  logic [8:0] bee_y;
  logic [1:0] state, lives;

  int tests = 0;
  int fails = 0;

  bee_game_ctrl dut (
    .clk_pix(clk_pix), .rst(rst), .sx(sx), .sy(sy), .btn_start(btn_start),
    .move_r(move_r), .move_l(move_l), .move_u(move_u), .move_d(move_d), .hit(hit),
    .frame_tick(frame_tick), .bee_x(bee_x), .bee_y(bee_y), .bee_en(bee_en),
    .state(state), .lives(lives)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, "_x"}, 32'(bee_x), 32'(ex));
    check({tag, "_y"}, 32'(bee_y), 32'(ey));
  endtask

  task automatic check_st(input string tag, input int es, input int el, input int een);
    check({tag, "_state"}, 32'(state), 32'(es));
    check({tag, "_lives"}, 32'(lives), 32'(el));
    check({tag, "_en"},    32'(bee_en), 32'(een));
  endtask

  // One frame: end-of-frame position for a cycle, then the tick cycle, ending after the update edge.
  task automatic frame();
    @(negedge clk_pix); sx = 10'd639; sy = 10'd479;
    @(negedge clk_pix); sx = 10'd17;  sy = 10'd23;
    @(negedge clk_pix);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic hit_pulse();
    @(negedge clk_pix); sx = 10'd200; hit = 1'b1;
    @(negedge clk_pix); hit = 1'b0;
  endtask

  // Hit raised only during the frame_tick cycle.
  task automatic frame_hit_on_tick();
    @(negedge clk_pix); sx = 10'd639; sy = 10'd479;
    @(negedge clk_pix); sx = 10'd17;  sy = 10'd23; hit = 1'b1;
    @(negedge clk_pix); hit = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_pix);
    check_st("reset", 0, 3, 1);
    check_pos("reset", 0, 300);
    check("reset_tick", 32'(frame_tick), 0);
    rst = 1'b0;

    // Start and move, then async reset mid-line.
    btn_start = 1'b1;
    frame();
    check("start_state", 32'(state), 1);
    btn_start = 1'b0;
    move_r = 1'b1;
    frames(3);
    check_pos("pre_rst", 9, 300);
    @(negedge clk_pix); sx = 10'd100; sy = 10'd50;
    #2 rst = 1'b1;
    #1;
    check_st("midrst", 0, 3, 1);
    check_pos("midrst", 0, 300);
    check("midrst_tick", 32'(frame_tick), 0);
    @(negedge clk_pix); rst = 1'b0;

    // frame_tick only follows the exact last pixel of the frame.
    @(negedge clk_pix); sx = 10'd639; sy = 10'd478;
    @(negedge clk_pix);
    check("tick_not_478", 32'(frame_tick), 0);
    sx = 10'd639; sy = 10'd479;
    @(negedge clk_pix); sx = 10'd0; sy = 10'd0;
    check("tick_after_eof", 32'(frame_tick), 1);
    @(negedge clk_pix);
    check("tick_one_cycle", 32'(frame_tick), 0);
    check_st("idle_hold", 0, 3, 1);
    check_pos("idle_hold", 0, 300);

    // Start held through play: no movement on the start tick.
    btn_start = 1'b1;
    frame();
    check("play_state", 32'(state), 1);
    check_pos("start_tick", 0, 300);
    frames(10);
    check_pos("right10", 30, 300);
    frames(240);
`ifdef WRAP_X_EN
    check_pos("right250", 141, 300);
    frame();
    check_pos("right251", 144, 300);
    move_r = 1'b0; move_l = 1'b1;
    frames(48);
    check_pos("left_to0", 0, 300);
    frame();
    check_pos("left_wrap", 606, 300);
    move_l = 1'b0; move_r = 1'b1;
    frame();
    check_pos("right_wrap", 0, 300);
`else
    check_pos("right250", 606, 300);
    frame();
    check_pos("right_clamp", 606, 300);
    move_r = 1'b0; move_l = 1'b1;
    frames(202);
    check_pos("left_to0", 0, 300);
    frame();
    check_pos("left_clamp", 0, 300);
    move_l = 1'b0; move_r = 1'b1;
`endif
    frame();
    check_pos("right_once", 3, 300);
    move_l = 1'b1;
    frame();
    check_pos("rl_both", 3, 300);
    move_r = 1'b0; move_l = 1'b0;

    // Vertical clamping and opposing buttons.
    move_d = 1'b1;
    frames(51);
    check_pos("down51", 3, 453);
    frame();
    check_pos("down_clamp", 3, 453);
    move_d = 1'b0; move_u = 1'b1;
    frame();
    check_pos("up_once", 3, 450);
    move_d = 1'b1;
    frame();
    check_pos("ud_both", 3, 450);
    move_d = 1'b0;
    frames(150);
    check_pos("up_to0", 3, 0);
    frame();
    check_pos("up_clamp", 3, 0);
    move_u = 1'b0;
    btn_start = 1'b0;

    // First hit: one-cycle mid-frame pulse with move_r held.
    move_r = 1'b1;
    hit_pulse();
    frame();
    check_st("hit1", 2, 2, 1);
    check_pos("hit1", 3, 0);
    for (int k = 2; k <= 60; k++) begin
      if (k == 30) hit_pulse();
      frame();
      check("hit_blink_state", 32'(state), 2);
      check("hit_blink_en", 32'(bee_en), 32'(((61 - k) >> 2) & 1));
    end
    check("hit_ignored_lives", 32'(lives), 2);
    check_pos("hit_moveless", 3, 0);
    frame();
    check_st("respawn1", 1, 2, 1);
    check_pos("respawn1", 0, 300);
    frame();
    check_st("after_respawn", 1, 2, 1);
    check_pos("after_respawn", 3, 300);
    move_r = 1'b0;

    // Second hit lands on the tick cycle itself.
    frame_hit_on_tick();
    check_st("hit2", 2, 1, 1);
    frames(60);
    check_st("respawn2", 1, 1, 1);
    check_pos("respawn2", 0, 300);

    // Third hit: game over; start held is ignored.
    hit_pulse();
    btn_start = 1'b1;
    frame();
    check_st("over", 3, 0, 0);
    frames(119);
    check_st("over_hold", 3, 0, 0);
    btn_start = 1'b0;
    frame();
    check_st("over_exit", 0, 3, 1);
    check_pos("over_exit", 0, 300);

    // Hit in IDLE has no effect.
    hit_pulse();
    frame();
    check_st("idle_hit", 0, 3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bee_game_ctrl.md
Name: bee_game_ctrl

Overview:
- Per-frame game sequencer for the bee sprite.
- Generates the frame tick from the VGA scan counters and samples the debounced direction and start buttons once per frame.
- Owns the bee position, with clamping, plus the lives counter and the IDLE/PLAY/HIT/OVER state machine.
- Drives bee_x, bee_y and bee_en into the bee sprite renderer, which then only does address generation and ROM lookup.

Parameters:
- H_RES, 640, active horizontal pixels
- V_RES, 480, active lines
- SPR_W, 34, bee width in pixels
- SPR_H, 27, bee height in pixels
- START_X, 0, bee reset/respawn X
- START_Y, 300, bee reset/respawn Y
- SPEED, 3, pixels moved per frame per axis (1..SPR_W)
- LIVES, 3, initial lives (1..3)
- HIT_FRAMES, 60, frames spent in HIT (>=2)
- OVER_FRAMES, 120, frames spent in OVER (>=2)

Ports:
- clk_pix  in  1  pixel clock, 25.2 MHz
- rst  in  1  asynchronous, active-high reset
- sx  in  10  current scan X
- sy  in  10  current scan Y
- btn_start  in  1  debounced start, level
- move_r  in  1  debounced right, level
- move_l  in  1  debounced left, level
- move_u  in  1  debounced up, level
- move_d  in  1  debounced down, level
- hit  in  1  collision strobe from hazard logic, any cycle, any width
- frame_tick  out  1  one-cycle pulse per frame
- bee_x  out  10  bee top-left X
- bee_y  out  9  bee top-left Y
- bee_en  out  1  sprite draw enable
- state  out  2  0=IDLE, 1=PLAY, 2=HIT, 3=OVER
- lives  out  2  remaining lives

Behaviour:
- Reset (async, rst=1): state=IDLE, bee_x=START_X, bee_y=START_Y, lives=LIVES, bee_en=1, frame_tick=0, frame timer=0, hit_pend=0. All outputs are registered.
- frame_tick: asserted the cycle after (sx==H_RES-1 && sy==V_RES-1) is seen. Exactly one pulse per frame. All state, position and lives updates occur only on a frame_tick cycle.
- hit_pend: set by hit=1 on any cycle while in PLAY. Cleared on every frame_tick and in any state other than PLAY. A hit on the same cycle as frame_tick counts for that tick.
- IDLE:
  - bee held at START_X/START_Y, bee_en=1, lives=LIVES.
  - On tick with btn_start=1: go to PLAY.
- PLAY:
  - bee_en=1.
  - On tick with hit_pend=1: lives decrements and no movement is applied that frame. If the new lives value is 0, go to OVER and load the timer with OVER_FRAMES; otherwise go to HIT and load the timer with HIT_FRAMES.
  - On tick without hit_pend: apply movement.
- Movement, per axis, evaluated independently:
  - Both opposing buttons pressed: no motion on that axis.
  - Right: bee_x = min(bee_x+SPEED, H_RES-SPR_W).
  - Left: bee_x = (bee_x>=SPEED) ? bee_x-SPEED : 0.
  - Up/down follow the same rules with V_RES-SPR_H and 0 as bounds.
  - Compute sums at 11 bits so there is no overflow; the result never leaves [0, H_RES-SPR_W] x [0, V_RES-SPR_H].
- HIT:
  - No movement; hits ignored.
  - bee_en = timer[2], giving a blink every 4 frames.
  - Timer decrements on each tick. On the tick where timer==1: bee_x=START_X, bee_y=START_Y, bee_en=1, go to PLAY.
- OVER:
  - bee_en=0; btn_start ignored.
  - Timer decrements per tick. On the tick where timer==1: go to IDLE, lives=LIVES, position set to start.
- Reset mid-frame or mid-state returns immediately to the reset values. The first frame_tick after reset is at the next end-of-frame.
- btn_start held continuously: IDLE->PLAY on the first tick only. Start has no effect in other states.

Optional Feature:
- Macro: WRAP_X_EN.
- Defined: horizontal motion wraps instead of clamping.
  - Moving right from bee_x > H_RES-SPR_W-SPEED gives bee_x=0.
  - Moving left from bee_x < SPEED gives bee_x=H_RES-SPR_W.
  - Vertical motion still clamps.
- Undefined: both axes clamp as described in Behaviour.

Test Plan:
- Async rst pulse mid-line -> next cycle state=0, bee_x=0, bee_y=300, lives=3, bee_en=1. frame_tick first appears one cycle after sx=639,sy=479.
- IDLE, btn_start=1 over one tick, then move_r held 10 frames -> state=1, bee_x=30. Continue to 250 frames -> bee_x=606 and holds there (wraps to 0 under WRAP_X_EN).
- PLAY at bee_y=2, move_u one frame -> bee_y=0. move_u+move_d together -> bee_y unchanged. move_d at bee_y=452 -> 453.
- hit pulse of 1 cycle mid-frame with move_r held -> at next tick lives=2, state=2, bee_x unchanged. bee_en toggles every 4 ticks. After 60 ticks state=1 at (0,300).
- Three hits, separated by recovery -> after third, lives=0, state=3, bee_en=0. btn_start held is ignored. After 120 ticks state=0, lives=3.
- hit asserted during HIT and during IDLE -> no lives change, no state change.
